// File: rtl/timer_dev.sv
// timer_dev: programmable down-counter with interrupt (CTRL/PRESET/COUNT).
// Optional: define TIMER_STATUS_EN to expose FSM state and irq_flag in CTRL[6:4].
module timer_dev #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000,
    parameter int          CTRL_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [1:0]  ADDR,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [31:0]         preset_q;
    logic [31:0]         count_q, count_d;
    logic                irq_q, irq_d;
    logic                wr_ctrl, wr_preset;
    logic                en, auto_rl;
    logic [31:0]         ctrl_rd;
    logic                unused_wd;

    assign unused_wd = ^WD[31:CTRL_W];

    assign wr_ctrl   = WE && (ADDR == 2'd0);
    assign wr_preset = WE && (ADDR == 2'd1);
    assign en        = ctrl_q[0];
    assign auto_rl   = (ctrl_q[2:1] == 2'b01);

    assign IRQ = ctrl_q[3] & irq_q;

    // Register all timer state; reset is immediate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= PRESET_RST;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            if (wr_preset) begin
                preset_q <= WD;
            end
        end
    end

    // Next-state: bus writes first, then FSM updates that take priority.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        count_d = count_q;
        irq_d   = irq_q;
        if (wr_ctrl) begin
            ctrl_d = WD[CTRL_W-1:0];
            irq_d  = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Terminal count beats a same-cycle CTRL write's flag clear.
                    count_d = '0;
                    irq_d   = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (auto_rl) begin
                    irq_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    // A same-cycle CTRL write keeps its own EN value.
                    if (!wr_ctrl) begin
                        ctrl_d[0] = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CTRL read view, optionally carrying FSM status.
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_W-1:0] = ctrl_q;
`ifdef TIMER_STATUS_EN
        ctrl_rd[5:4] = state_q;
        ctrl_rd[6]   = irq_q;
`endif
    end

    // Read mux, combinational from ADDR.
    always_comb begin
        RD = '0;
        unique case (ADDR)
            2'd0:    RD = ctrl_rd;
            2'd1:    RD = preset_q;
            2'd2:    RD = count_q;
            default: RD = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed stimulus with a queued scoreboard for timer_dev.
// Expected RD/IRQ values are queued per cycle and checked by a monitor.
module tb_timer_dev;

    localparam logic [31:0] PRST = 32'h0000_0A5A;
    localparam logic [31:0] CMASK =
`ifdef TIMER_STATUS_EN
        32'h0000_000F;
`else
        32'hFFFF_FFFF;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [1:0]  ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        bit          is_irq;
        logic [31:0] val;
        logic [31:0] mask;
        logic [63:0] tag;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [31:0] act;

    int b_cnt[9]  = '{0, 0, 5, 4, 3, 2, 1, 0, 0};
    logic [8:0] b_irq = 9'h180;
    int c_cnt[22] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0,
                      0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    logic [21:0] c_irq = 22'h108420;
    int d_cnt[9]  = '{2, 2, 4, 3, 2, 1, 0, 0, 0};
    int d2_cnt[8] = '{0, 0, 4, 3, 2, 1, 0, 0};
    logic [7:0] d2_irq = 8'hC0;
    int e_cnt[6]  = '{0, 0, 6, 5, 4, 3};
    int f_cnt[5]  = '{4, 4, 0, 0, 0};
    logic [4:0] f_irq = 5'h18;

    timer_dev #(
        .PRESET_RST(PRST),
        .CTRL_W    (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .WE   (WE),
        .ADDR (ADDR),
        .WD   (WD),
        .RD   (RD),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = e.is_irq ? {31'd0, IRQ} : RD;
            checks++;
            if (e.cyc != cyc || ((act ^ e.val) & e.mask) !== 32'd0) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h",
                         e.tag, cyc, act, e.val);
            end
        end
    end

    task automatic put(bit is_irq, logic [31:0] v,
                       logic [31:0] m, logic [63:0] tag);
        exp_t x;
        x.cyc    = cyc;
        x.is_irq = is_irq;
        x.val    = v;
        x.mask   = m;
        x.tag    = tag;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        WE = 1'b0;
        WD = '0;
    endtask

    task automatic rd(logic [1:0] a, logic [31:0] v, logic [63:0] tag);
        ADDR = a;
        put(1'b0, v, 32'hFFFF_FFFF, tag);
    endtask

    task automatic rdc(logic [31:0] v, logic [63:0] tag);
        ADDR = 2'd0;
        put(1'b0, v, CMASK, tag);
    endtask

    task automatic ex_irq(bit v, logic [63:0] tag);
        put(1'b1, {31'd0, v}, 32'h1, tag);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        WE   = 1'b1;
        ADDR = a;
        WD   = d;
        tick();
    endtask

    // Keep the run bounded even if something stalls.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        ADDR  = 2'd0;
        WD    = '0;
        tick();

        // Reset values
        rdc(32'h0, "rst_ctl"); ex_irq(1'b0, "rst_irq"); tick();
        rd(2'd1, PRST, "rst_pre"); tick();
        rd(2'd2, 32'h0, "rst_cnt"); tick();
        rd(2'd3, 32'h0, "rst_un"); tick();
        reset = 1'b0;

        // One-shot, IM set: level IRQ until CTRL write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int w = 0; w < 9; w++) begin
            rd(2'd2, b_cnt[w], "B_cnt");
            ex_irq(b_irq[w], "B_irq");
            tick();
        end
        rdc(32'h8, "B_ctl"); ex_irq(1'b1, "B_hold"); tick();
        rdc(32'h8, "B_ctl2"); ex_irq(1'b1, "B_hold2");
        WE = 1'b1; WD = 32'h0; tick();
        rdc(32'h0, "B_clr"); ex_irq(1'b0, "B_drop"); tick();

        // Auto-reload: pulse every 5 cycles
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int w = 0; w < 22; w++) begin
            rd(2'd2, c_cnt[w], "C_cnt");
            ex_irq(c_irq[w], "C_irq");
            tick();
        end
        rdc(32'hB, "C_ctl"); WE = 1'b1; WD = 32'h0; tick();
        for (int w = 0; w < 3; w++) begin
            rd(2'd2, 32'd2, "C_hold");
            tick();
        end

        // IM clear: flag sets silently, CTRL write clears and restarts
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        for (int w = 0; w < 9; w++) begin
            rd(2'd2, d_cnt[w], "D_cnt");
            ex_irq(1'b0, "D_mask");
            tick();
        end
        rdc(32'h0, "D_ctl"); ex_irq(1'b0, "D_irq");
        WE = 1'b1; WD = 32'h9; tick();
        for (int w = 0; w < 8; w++) begin
            rd(2'd2, d2_cnt[w], "D2_cnt");
            ex_irq(d2_irq[w], "D2_irq");
            tick();
        end
        rdc(32'h8, "D2_ctl"); ex_irq(1'b1, "D2_hold");
        WE = 1'b1; WD = 32'h0; tick();
        rd(2'd2, 32'd0, "D2_c0"); ex_irq(1'b0, "D2_drop"); tick();

        // Mid-count PRESET/COUNT/unmapped writes in auto-reload
        wr(2'd1, 32'd6);
        wr(2'd0, 32'hB);
        for (int w = 0; w < 6; w++) begin
            rd(2'd2, e_cnt[w], "E_cnt");
            ex_irq(1'b0, "E_irq");
            tick();
        end
        rd(2'd1, 32'd6, "E_pre0"); WE = 1'b1; WD = 32'd10; tick();
        rd(2'd2, 32'd1, "E_c1"); ex_irq(1'b0, "E_i1"); tick();
        rd(2'd2, 32'd0, "E_c0"); ex_irq(1'b1, "E_pulse"); tick();
        rd(2'd2, 32'd0, "E_load"); ex_irq(1'b0, "E_i0"); tick();
        rd(2'd2, 32'd10, "E_rl10"); WE = 1'b1; WD = 32'h55; tick();
        rd(2'd2, 32'd9, "E_cwr"); tick();
        rd(2'd3, 32'd0, "E_un"); WE = 1'b1; WD = 32'hFFFF_FFFF; tick();
        rdc(32'hB, "E_ctl"); tick();
        rd(2'd1, 32'd10, "E_pre"); tick();
        rdc(32'hB, "E_ctl2"); WE = 1'b1; WD = 32'h0; tick();
        rd(2'd2, 32'd4, "E_stop"); tick();
        rd(2'd2, 32'd4, "E_idle"); tick();

        // PRESET=0 acts as 1
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int w = 0; w < 5; w++) begin
            rd(2'd2, f_cnt[w], "F_cnt");
            ex_irq(f_irq[w], "F_irq");
            tick();
        end
        rdc(32'h8, "F_ctl"); ex_irq(1'b1, "F_hold");
        WE = 1'b1; WD = 32'h0; tick();
        rd(2'd2, 32'd0, "F_c0"); ex_irq(1'b0, "F_drop"); tick();

`ifdef TIMER_STATUS_EN
        // Status bits follow the FSM
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        ADDR = 2'd0; put(1'b0, 32'h01, 32'hFFFF_FFFF, "S_idle"); tick();
        ADDR = 2'd0; put(1'b0, 32'h11, 32'hFFFF_FFFF, "S_load"); tick();
        ADDR = 2'd0; put(1'b0, 32'h21, 32'hFFFF_FFFF, "S_cnt"); tick();
        ADDR = 2'd0; put(1'b0, 32'h21, 32'hFFFF_FFFF, "S_cnt2"); tick();
        ADDR = 2'd0; put(1'b0, 32'h71, 32'hFFFF_FFFF, "S_int"); tick();
        ADDR = 2'd0; put(1'b0, 32'h40, 32'hFFFF_FFFF, "S_done");
        WE = 1'b1; WD = 32'h0; tick();
        ADDR = 2'd0; put(1'b0, 32'h00, 32'hFFFF_FFFF, "S_clr"); tick();
`endif

        // Reset mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        rd(2'd2, 32'd0, "G_c0"); tick();
        rd(2'd2, 32'd0, "G_c1"); tick();
        rd(2'd2, 32'd5, "G_c2"); tick();
        rd(2'd2, 32'd4, "G_c3"); tick();
        reset = 1'b1;
        rd(2'd2, 32'd0, "G_rcnt"); ex_irq(1'b0, "G_rirq"); tick();
        rdc(32'h0, "G_rctl"); tick();
        rd(2'd1, PRST, "G_rpre"); tick();
        reset = 1'b0;
        rd(2'd2, 32'd0, "G_idle"); ex_irq(1'b0, "G_irq"); tick();
        rd(2'd2, 32'd0, "G_idle2"); tick();

        tick();
        tick();
        if (q.size() != 0) begin
            $display("FAIL leftover got=%0d want=0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
